wb_ddr_bridge: RTL and testbench

- Parametrised Wishbone slave that bridges the bus to the ddr_controller user-command interface.
- Successor to the single-outstanding sdram slave: adds a posted-write FIFO with ordering against reads, a per-command timeout, an addressable status/control register, sticky error flags and a maskable interrupt.
- Sits between the Wishbone interconnect and ddr_controller in the same clock domain.

---
 rtl/wb_ddr_bridge.sv | 154 +++++++++++++++
 tb/tb_wb_ddr_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ddr_bridge.sv
// wb_ddr_bridge: Wishbone slave bridging to the ddr_controller user-command interface
module wb_ddr_bridge #(
   parameter int          DATA_WIDTH  = 32,
   parameter int          ADDR_WIDTH  = 24,
   parameter int          WFIFO_DEPTH = 4,
   parameter int          TIMEOUT     = 1024,
   parameter logic [31:0] STATUS_ADDR = 32'h00FFFFFF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wbs_we_i,
   input  logic                  wbs_cyc_i,
   input  logic                  wbs_stb_i,
   input  logic [31:0]           wbs_adr_i,
   input  logic [DATA_WIDTH-1:0] wbs_dat_i,
   output logic [DATA_WIDTH-1:0] wbs_dat_o,
   output logic                  wbs_ack_o,
   output logic                  wbs_int_o,
   output logic [3:0]            user_cmd,
   output logic                  user_cmd_vld,
   output logic [ADDR_WIDTH-1:0] user_addr,
   output logic [DATA_WIDTH-1:0] user_data_in,
   output logic                  user_confirm,
   input  logic [DATA_WIDTH-1:0] user_data_out,
   input  logic                  user_data_out_vld,
   input  logic                  ddr_busy,
   input  logic                  ddr_ack,
   input  logic                  ddr_ready
);
   localparam int PW = $clog2(WFIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WR_ISSUE = 3'd1;
   localparam logic [2:0] WR_WAIT  = 3'd2;
   localparam logic [2:0] RD_ISSUE = 3'd3;
   localparam logic [2:0] RD_WAIT  = 3'd4;
   localparam logic [2:0] CONFIRM  = 3'd5;

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_mem_q [WFIFO_DEPTH];
   logic [DATA_WIDTH-1:0] data_mem_q [WFIFO_DEPTH];
   logic [PW-1:0]         wp_q, rp_q;
   logic [LW-1:0]         level_q, level_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [DATA_WIDTH-1:0] dat_q, dat_d, status;
   logic                  ack_q, ack_d, int_q, int_en_q, int_en_d;
   logic                  ts_q, ts_d, ds_q, ds_d;
   logic                  req, is_stat, full, empty, push, pop, rd_pend;
   logic                  expired, rd_done, rd_to, wr_to, stat_wr, stat_clr, drop;

   // A request is only considered while it is still unacknowledged
   assign req      = wbs_stb_i & wbs_cyc_i & ~ack_q;
   assign is_stat  = wbs_adr_i == STATUS_ADDR;
   assign full     = level_q == LW'(WFIFO_DEPTH);
   assign empty    = level_q == '0;
   // Full is the registered level, so a write stalled on full lands the cycle after the pop
   assign push     = req & wbs_we_i & ~is_stat & ddr_ready & ~full;
   assign rd_pend  = req & ~wbs_we_i & ~is_stat & ddr_ready;
   assign drop     = req & ~is_stat & ~ddr_ready;
   assign stat_wr  = req & is_stat & wbs_we_i;
   assign stat_clr = stat_wr & wbs_dat_i[0];
   assign expired  = cnt_q == CW'(TIMEOUT - 1);
   assign rd_done  = (state_q == RD_WAIT) & user_data_out_vld;
   assign rd_to    = (state_q == RD_WAIT) & ~user_data_out_vld & expired;
   assign wr_to    = (state_q == WR_WAIT) & ~ddr_ack & expired;
   assign pop      = (state_q == WR_WAIT) & (ddr_ack | expired);

   assign wbs_dat_o    = dat_q;
   assign wbs_ack_o    = ack_q;
   assign wbs_int_o    = int_q;
   assign user_cmd     = {3'b000, state_q == WR_ISSUE};
   assign user_cmd_vld = (state_q == WR_ISSUE) | (state_q == RD_ISSUE);
   assign user_addr    = (state_q == WR_ISSUE) ? addr_mem_q[rp_q] : (state_q == RD_ISSUE) ? rd_addr_q : '0;
   assign user_data_in = ((state_q == WR_ISSUE) | (state_q == WR_WAIT)) ? data_mem_q[rp_q] : '0;
   assign user_confirm = state_q == CONFIRM;

   // Status/control register image
   always_comb begin
      status       = '0;
      status[12:8] = 5'(level_q);
      status[6:0]  = {int_en_q, ts_q, ds_q, full, ddr_busy, ddr_ack, ddr_ready};
   end

   // Command sequencing: reads wait for an empty FIFO and never overtake posted writes
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     state_d = ddr_busy ? IDLE : ~empty ? WR_ISSUE : rd_pend ? RD_ISSUE : IDLE;
         WR_ISSUE: state_d = WR_WAIT;
         WR_WAIT:  state_d = ddr_ack ? CONFIRM : expired ? IDLE : WR_WAIT;
         RD_ISSUE: state_d = RD_WAIT;
         RD_WAIT:  state_d = user_data_out_vld ? CONFIRM : expired ? IDLE : RD_WAIT;
         CONFIRM:  state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Bus response, timeout counter, FIFO level and sticky flag next-state
   always_comb begin
      ack_d     = ack_q ? (wbs_stb_i & wbs_cyc_i)
                        : (req & (is_stat | ~ddr_ready | (wbs_we_i & ~full))) | rd_done | rd_to;
      dat_d     = rd_done ? user_data_out
                : (rd_to | (drop & ~wbs_we_i)) ? '1
                : (req & is_stat & ~wbs_we_i) ? status : dat_q;
      cnt_d     = ((state_q == WR_ISSUE) | (state_q == RD_ISSUE) | (state_q == WR_WAIT) | (state_q == RD_WAIT))
                ? cnt_q + CW'(1) : '0;
      rd_addr_d = ((state_q == IDLE) & rd_pend) ? wbs_adr_i[ADDR_WIDTH-1:0] : rd_addr_q;
      level_d   = level_q + LW'(push) - LW'(pop);
      ds_d      = (ds_q & ~stat_clr) | drop;
      ts_d      = (ts_q & ~stat_clr) | rd_to | wr_to;
      int_en_d  = stat_wr ? wbs_dat_i[1] : int_en_q;
   end

   // Control state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wp_q      <= '0;
         rp_q      <= '0;
         level_q   <= '0;
         cnt_q     <= '0;
         rd_addr_q <= '0;
         dat_q     <= '0;
         ack_q     <= 1'b0;
         int_q     <= 1'b0;
         int_en_q  <= 1'b0;
         ts_q      <= 1'b0;
         ds_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         wp_q      <= push ? wp_q + PW'(1) : wp_q;
         rp_q      <= pop ? rp_q + PW'(1) : rp_q;
         level_q   <= level_d;
         cnt_q     <= cnt_d;
         rd_addr_q <= rd_addr_d;
         dat_q     <= dat_d;
         ack_q     <= ack_d;
         int_q     <= int_en_q & (ts_q | ds_q);
         int_en_q  <= int_en_d;
         ts_q      <= ts_d;
         ds_q      <= ds_d;
      end
   end

   // Posted-write storage; contents are don't-care until pushed
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem_q[wp_q] <= wbs_adr_i[ADDR_WIDTH-1:0];
         data_mem_q[wp_q] <= wbs_dat_i;
      end
   end
endmodule

// File: tb/tb_wb_ddr_bridge.sv
// tb_wb_ddr_bridge: scoreboard bench for wb_ddr_bridge with a behavioural memory model
module tb_wb_ddr_bridge;
   localparam int          TO   = 16;
   localparam logic [31:0] STAT = 32'h00FFFFFF;

   typedef struct { bit rd; logic [31:0] d; } ack_t;
   typedef struct { logic [3:0] c; logic [23:0] a; logic [31:0] d; } cmd_t;

   logic        clk = 0, rst = 1;
   logic        wbs_we_i = 0, wbs_cyc_i = 0, wbs_stb_i = 0;
   logic [31:0] wbs_adr_i = 0, wbs_dat_i = 0, wbs_dat_o;
   logic        wbs_ack_o, wbs_int_o;
   logic [3:0]  user_cmd;
   logic        user_cmd_vld, user_confirm;
   logic [23:0] user_addr;
   logic [31:0] user_data_in;
   logic [31:0] user_data_out = 0;
   logic        user_data_out_vld = 0, ddr_busy = 0, ddr_ack = 0, ddr_ready = 1;

   ack_t        exp_ack[$];
   cmd_t        exp_cmd[$];
   logic [31:0] ref_mem [int];
   logic [31:0] ddr_mem [int];
   int          n_chk = 0, n_fail = 0, cyc = 0, n_conf = 0, n_vld = 0;
   int          rd_vld_cyc = 0, rd_vld_conf = 0, last_conf_cyc = 0, last_ack_cyc = 0, last_lat = 0;
   bit          resp_en = 1, rand_busy = 0, busy_man = 0;

   wb_ddr_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(24), .WFIFO_DEPTH(4), .TIMEOUT(TO), .STATUS_ADDR(STAT)) dut (
      .clk(clk), .rst(rst),
      .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_adr_i(wbs_adr_i),
      .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_int_o(wbs_int_o),
      .user_cmd(user_cmd), .user_cmd_vld(user_cmd_vld), .user_addr(user_addr),
      .user_data_in(user_data_in), .user_confirm(user_confirm), .user_data_out(user_data_out),
      .user_data_out_vld(user_data_out_vld), .ddr_busy(ddr_busy), .ddr_ack(ddr_ack), .ddr_ready(ddr_ready)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] init_val(input logic [23:0] a);
      return {8'hA5, a} ^ 32'h13579BDF;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   // Controller model: answers each command after a random delay
   logic [3:0]  r_c;
   logic [23:0] r_a;
   logic [31:0] r_d;
   initial forever begin
      @(posedge clk); #1;
      if (user_cmd_vld && resp_en && !rst) begin
         r_c = user_cmd; r_a = user_addr; r_d = user_data_in;
         repeat ($urandom_range(1, 12)) @(posedge clk);
         #1;
         if (r_c == 4'd1) begin
            ddr_mem[int'(r_a)] = r_d;
            ddr_ack = 1;
         end else begin
            user_data_out = ddr_mem.exists(int'(r_a)) ? ddr_mem[int'(r_a)] : init_val(r_a);
            user_data_out_vld = 1;
         end
         @(posedge clk); #1;
         ddr_ack = 0; user_data_out_vld = 0; user_data_out = $urandom;
      end
   end

   initial forever begin
      ddr_busy = rand_busy ? ($urandom_range(0, 3) == 0) : busy_man;
      @(posedge clk); #2;
   end

   // Bus response monitor
   initial begin
      bit   ack_prev = 0;
      ack_t e;
      forever begin
         @(posedge clk); #1;
         if (wbs_ack_o && !ack_prev) begin
            if (exp_ack.size() == 0) check("unexpected_ack", 1, 0);
            else begin
               e = exp_ack.pop_front();
               if (e.rd) check("read_data", wbs_dat_o, e.d);
            end
         end
         ack_prev = wbs_ack_o;
      end
   end

   // Controller command monitor
   initial begin
      cmd_t e;
      forever begin
         @(posedge clk); #1;
         if (user_confirm) begin n_conf++; last_conf_cyc = cyc; end
         if (user_cmd_vld) begin
            n_vld++;
            if (exp_cmd.size() == 0) check("unexpected_cmd", 1, 0);
            else begin
               e = exp_cmd.pop_front();
               check("cmd", user_cmd, e.c);
               check("cmd_addr", user_addr, e.a);
               if (e.c == 4'd1) check("cmd_wdata", user_data_in, e.d);
            end
            if (user_cmd == 4'd0) begin rd_vld_cyc = cyc; rd_vld_conf = n_conf; end
         end
      end
   end

   task automatic wb(input bit we, input logic [31:0] adr, input logic [31:0] dat);
      @(posedge clk); #1;
      wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat; wbs_cyc_i = 1; wbs_stb_i = 1;
      last_lat = 0;
      do begin @(posedge clk); #1; last_lat++; end while (!wbs_ack_o && last_lat < 500);
      if (!wbs_ack_o) check("ack_timeout", 0, 1);
      last_ack_cyc = cyc;
      wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
   endtask

   task automatic mem_wr(input logic [23:0] a, input logic [31:0] d, input int exp_lat);
      ack_t e;
      cmd_t c;
      if (ddr_ready) begin
         ref_mem[int'(a)] = d;
         c.c = 4'd1; c.a = a; c.d = d;
         exp_cmd.push_back(c);
      end
      e.rd = 0; e.d = 0;
      exp_ack.push_back(e);
      wb(1, {8'h00, a}, d);
      if (exp_lat > 0) check("wr_latency", last_lat, exp_lat);
   endtask

   task automatic mem_rd(input logic [23:0] a, input int exp_lat);
      ack_t e;
      cmd_t c;
      e.rd = 1;
      e.d = (!ddr_ready || !resp_en) ? 32'hFFFFFFFF
          : ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
      if (ddr_ready) begin c.c = 4'd0; c.a = a; c.d = 0; exp_cmd.push_back(c); end
      exp_ack.push_back(e);
      wb(0, {8'h00, a}, $urandom);
      if (exp_lat > 0) check("rd_latency", last_lat, exp_lat);
   endtask

   task automatic st_rd(input logic [31:0] exp);
      ack_t e;
      e.rd = 1; e.d = exp;
      exp_ack.push_back(e);
      wb(0, STAT, 0);
      check("status_rd_latency", last_lat, 1);
   endtask

   task automatic st_wr(input logic [31:0] d);
      ack_t e;
      e.rd = 0; e.d = 0;
      exp_ack.push_back(e);
      wb(1, STAT, d);
      check("status_wr_latency", last_lat, 1);
   endtask

   task automatic drain();
      int k = 0;
      while (exp_cmd.size() != 0 && k < 3000) begin @(posedge clk); #1; k++; end
      if (exp_cmd.size() != 0) check("drain_cmds_pending", exp_cmd.size(), 0);
      repeat (20) @(posedge clk);
      #1;
   endtask

   initial begin
      int c0, v0, k;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", wbs_ack_o, 0);
      check("rst_dat", wbs_dat_o, 0);
      check("rst_int", wbs_int_o, 0);
      check("rst_cmd", {user_cmd, user_cmd_vld, user_confirm}, 0);
      check("rst_addr_data", {user_addr, user_data_in}, 0);
      rst = 0;

      // Single posted write
      c0 = n_conf;
      mem_wr(24'h000010, 32'h00001EAF, 1);
      drain();
      check("t1_confirms", n_conf - c0, 1);
      st_rd(32'h00000001);

      // FIFO fill under busy, fifth write waits for the first pop
      busy_man = 1;
      for (int i = 0; i < 4; i++) mem_wr(24'h000100 + 24'(i), $urandom, 1);
      st_rd(32'h0000040D);
      c0 = n_conf;
      fork
         mem_wr(24'h000104, $urandom, 0);
         begin repeat (3) @(posedge clk); #1; busy_man = 0; end
      join
      check("t2_wr5_stalled", last_lat > 3, 1);
      check("t2_wr5_after_pop", last_ack_cyc, last_conf_cyc + 1);
      check("t2_one_pop_before_ack", n_conf - c0, 1);
      drain();

      // Read ordered behind posted writes
      c0 = n_conf;
      mem_wr(24'h00001C, $urandom, 1);
      mem_wr(24'h000020, 32'hCAFEF00D, 1);
      mem_rd(24'h000020, 0);
      check("t3_read_after_writes", rd_vld_conf - c0, 2);
      drain();
      check("t3_confirms", n_conf - c0, 3);

      // Randomised traffic with a randomly busy controller
      rand_busy = 1;
      repeat (60) begin
         k = $urandom_range(0, 15);
         if ($urandom_range(0, 1) == 1) mem_wr(24'h000040 + 24'(k), $urandom, 0);
         else mem_rd(24'h000040 + 24'(k), 0);
      end
      drain();
      rand_busy = 0;

      // Read timeout, interrupt and sticky clear
      resp_en = 0;
      st_wr(32'h2);
      c0 = n_conf;
      mem_rd(24'h000048, 0);
      check("t4_timeout_latency", last_ack_cyc - rd_vld_cyc, TO);
      drain();
      check("t4_no_confirm", n_conf - c0, 0);
      st_rd(32'h00000061);
      check("t4_int_set", wbs_int_o, 1);
      st_wr(32'h3);
      st_rd(32'h00000041);
      check("t4_int_clear", wbs_int_o, 0);
      resp_en = 1;

      // Controller not ready: requests are dropped
      ddr_ready = 0;
      v0 = n_vld;
      mem_wr(24'h000030, 32'h12345678, 1);
      mem_rd(24'h000030, 1);
      st_rd(32'h00000050);
      repeat (2) @(posedge clk);
      #1;
      check("t5_int_set", wbs_int_o, 1);
      check("t5_no_cmd", n_vld - v0, 0);
      st_wr(32'h1);
      ddr_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      check("t5_int_clear", wbs_int_o, 0);

      // Reset while a write is in flight with entries queued
      resp_en = 0;
      busy_man = 1;
      for (int i = 0; i < 3; i++) mem_wr(24'h500000 + 24'(i), $urandom, 1);
      busy_man = 0;
      k = 0;
      while (!user_cmd_vld && k < 100) begin @(posedge clk); #1; k++; end
      check("t6_first_issue", user_cmd_vld, 1);
      @(posedge clk); #1;
      c0 = n_conf;
      rst = 1;
      @(posedge clk); #1;
      check("t6_rst_bus", {wbs_ack_o, wbs_int_o, wbs_dat_o}, 0);
      check("t6_rst_user", {user_cmd, user_cmd_vld, user_confirm, user_addr, user_data_in}, 0);
      rst = 0;
      exp_cmd.delete();
      v0 = n_vld;
      repeat (30) @(posedge clk);
      #1;
      check("t6_no_confirm", n_conf - c0, 0);
      check("t6_no_cmd", n_vld - v0, 0);
      st_rd(32'h00000001);
      resp_en = 1;

      repeat (5) @(posedge clk);
      #1;
      if (exp_ack.size() != 0) check("acks_outstanding", exp_ack.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
